// File: rtl/commit_scoreboard.sv
// In-order commit scoreboard: buffers per-cycle commit events and
// checks them one per cycle against a golden trace record stream.
module commit_scoreboard #(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    cm_valid,
  input  logic [3*NUM_CH-1:0]  cm_type,
  input  logic [32*NUM_CH-1:0] cm_pc,
  input  logic [32*NUM_CH-1:0] cm_instr,
  input  logic [32*NUM_CH-1:0] cm_value,
  input  logic [32*NUM_CH-1:0] cm_addr,
  input  logic [5*NUM_CH-1:0]  cm_rd,
  input  logic                 trap_i,
  input  logic                 g_valid,
  output logic                 g_ready,
  input  logic [2:0]           g_type,
  input  logic [31:0]          g_pc,
  input  logic [31:0]          g_instr,
  input  logic [31:0]          g_value,
  input  logic [31:0]          g_addr,
  input  logic [4:0]           g_rd,
  output logic                 cm_stall,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     golden_idx,
  output logic                 err_valid,
  output logic [CNT_W-1:0]     err_idx,
  output logic [31:0]          err_pc,
  output logic [31:0]          err_exp,
  output logic [31:0]          err_got,
  output logic                 overflow,
  output logic                 timeout,
  output logic                 done,
  output logic                 test_pass
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] value;
    logic [31:0] addr;
    logic [4:0]  rd;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          rec_in [NUM_CH];
  rec_t          head;
  logic [PW-1:0] wptr, rptr, occ, free, n_push;
  logic [PW-1:0] slot_off [NUM_CH];
  logic [NUM_CH-1:0] acc;
  logic [1:0]    state;
  logic [IW-1:0] idle;
  logic          push_ok, drop, pop, act, to_hit;
  logic          base_eq, val_eq, match;

  assign occ      = wptr - rptr;
  assign free     = PW'(DEPTH) - occ;
  assign cm_stall = free < PW'(NUM_CH);
  assign push_ok  = (state == S_RUN) && !trap_i;
  assign pop      = (state != S_DONE) && (occ != '0) && g_valid;
  assign g_ready  = pop;
  assign head     = mem[rptr[AW-1:0]];
  assign done     = state == S_DONE;
  assign test_pass = done && (mismatch_cnt == '0) && !overflow && !timeout;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rec_in[i].typ   = cm_type[3*i +: 3];
      rec_in[i].pc    = cm_pc[32*i +: 32];
      rec_in[i].instr = cm_instr[32*i +: 32];
      rec_in[i].value = cm_value[32*i +: 32];
      rec_in[i].addr  = cm_addr[32*i +: 32];
      rec_in[i].rd    = cm_rd[5*i +: 5];
    end
  end

  // Lower channels claim free slots first; the rest are dropped.
  always_comb begin
    acc    = '0;
    drop   = 1'b0;
    n_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_off[i] = n_push;
      if (push_ok && cm_valid[i]) begin
        if (n_push < free) begin
          acc[i] = 1'b1;
          n_push = n_push + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    base_eq = (head.typ == g_type) && (head.pc == g_pc) &&
              (head.instr == g_instr);
    val_eq  = head.value == g_value;
    match   = base_eq;
    unique case (1'b1)
      g_type == 3'd0: match = base_eq && val_eq && head.rd == g_rd;
      g_type == 3'd1: match = base_eq && val_eq && head.addr == g_addr;
      g_type == 3'd2: match = base_eq && val_eq &&
                              head.rd == g_rd && head.addr == g_addr;
      default:        match = base_eq;
    endcase
  end

  assign act    = pop || (n_push != '0);
  assign to_hit = (TIMEOUT != 0) && !act && ((idle + 1'b1) == IW'(TIMEOUT));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (acc[i]) mem[AW'(wptr + slot_off[i])] <= rec_in[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      state        <= S_RUN;
      idle         <= '0;
      pass_cnt     <= '0;
      mismatch_cnt <= '0;
      golden_idx   <= '0;
      err_valid    <= 1'b0;
      err_idx      <= '0;
      err_pc       <= '0;
      err_exp      <= '0;
      err_got      <= '0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      wptr <= wptr + n_push;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rptr       <= rptr + 1'b1;
        golden_idx <= sat_inc(golden_idx);
        if (match) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          mismatch_cnt <= sat_inc(mismatch_cnt);
          if (!err_valid) begin
            err_valid <= 1'b1;
            err_idx   <= golden_idx;
            err_pc    <= g_pc;
            err_exp   <= val_eq ? g_addr : g_value;
            err_got   <= val_eq ? head.addr : head.value;
          end
        end
      end
      if (state != S_DONE) begin
        if (act) idle <= '0;
        else if (TIMEOUT != 0) idle <= idle + 1'b1;
      end
      unique case (1'b1)
        state == S_RUN: begin
          if (to_hit) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else if (trap_i) begin
            state <= S_DRAIN;
          end
        end
        state == S_DRAIN: begin
          if (to_hit) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else if (occ == '0) begin
            state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_scoreboard.sv
// Bench for commit_scoreboard: directed cases plus a randomized
// commit stream with golden corruptions, checked by a scoreboard.
`timescale 1ns/1ps
module tb_commit_scoreboard;
  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int CW  = 16;
  localparam int TO  = 16;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] value;
    logic [31:0] addr;
    logic [4:0]  rd;
  } rec_t;

  typedef struct {
    bit          ok;
    logic [31:0] pc;
    logic [31:0] exp;
    logic [31:0] got;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH-1:0]    cm_valid = '0;
  logic [3*NCH-1:0]  cm_type = '0;
  logic [32*NCH-1:0] cm_pc = '0, cm_instr = '0, cm_value = '0, cm_addr = '0;
  logic [5*NCH-1:0]  cm_rd = '0;
  logic trap_i = 1'b0;
  logic g_valid = 1'b0;
  logic g_ready;
  logic [2:0]  g_type = '0;
  logic [31:0] g_pc = '0, g_instr = '0, g_value = '0, g_addr = '0;
  logic [4:0]  g_rd = '0;
  logic cm_stall;
  logic [CW-1:0] pass_cnt, mismatch_cnt, golden_idx, err_idx;
  logic err_valid;
  logic [31:0] err_pc, err_exp, err_got;
  logic overflow, timeout, done, test_pass;

  commit_scoreboard #(
    .NUM_CH(NCH), .DEPTH(DEP), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cm_valid(cm_valid), .cm_type(cm_type), .cm_pc(cm_pc),
    .cm_instr(cm_instr), .cm_value(cm_value), .cm_addr(cm_addr),
    .cm_rd(cm_rd), .trap_i(trap_i),
    .g_valid(g_valid), .g_ready(g_ready), .g_type(g_type),
    .g_pc(g_pc), .g_instr(g_instr), .g_value(g_value),
    .g_addr(g_addr), .g_rd(g_rd),
    .cm_stall(cm_stall), .pass_cnt(pass_cnt),
    .mismatch_cnt(mismatch_cnt), .golden_idx(golden_idx),
    .err_valid(err_valid), .err_idx(err_idx), .err_pc(err_pc),
    .err_exp(err_exp), .err_got(err_got),
    .overflow(overflow), .timeout(timeout), .done(done),
    .test_pass(test_pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  rec_t gq[$];
  res_t xq[$];
  rec_t c_rec [NCH];
  rec_t g_rec [NCH];
  int m_pass = 0, m_mis = 0, m_idx = 0;
  bit m_err = 0;
  logic [31:0] m_eidx, m_epc, m_eexp, m_egot;
  bit gen = 0;
  int gmode = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic rec_t mk(input int typ, input logic [31:0] pc,
                              input logic [31:0] value,
                              input logic [31:0] addr, input int rd);
    rec_t r;
    r.typ = 3'(typ);
    r.pc = pc;
    r.instr = 32'h0000_0013 ^ pc;
    r.value = value;
    r.addr = addr;
    r.rd = 5'(rd);
    return r;
  endfunction

  // Expected outcome of comparing a committed record with its golden record.
  function automatic res_t judge(input rec_t c, input rec_t g);
    res_t r;
    bit ok;
    bit same_val;
    ok = c.typ == g.typ && c.pc == g.pc && c.instr == g.instr;
    same_val = c.value == g.value;
    case (g.typ)
      3'd0: ok = ok && same_val && c.rd == g.rd;
      3'd1: ok = ok && same_val && c.addr == g.addr;
      3'd2: ok = ok && same_val && c.rd == g.rd && c.addr == g.addr;
      default: ;
    endcase
    r.ok = ok;
    r.pc = g.pc;
    r.exp = same_val ? g.addr : g.value;
    r.got = same_val ? c.addr : c.value;
    return r;
  endfunction

  task automatic commit_cycle(input logic [NCH-1:0] v, input bit enq);
    for (int i = 0; i < NCH; i++) begin
      cm_type[3*i +: 3]    = c_rec[i].typ;
      cm_pc[32*i +: 32]    = c_rec[i].pc;
      cm_instr[32*i +: 32] = c_rec[i].instr;
      cm_value[32*i +: 32] = c_rec[i].value;
      cm_addr[32*i +: 32]  = c_rec[i].addr;
      cm_rd[5*i +: 5]      = c_rec[i].rd;
      if (enq && v[i]) begin
        gq.push_back(g_rec[i]);
        xq.push_back(judge(c_rec[i], g_rec[i]));
      end
    end
    cm_valid = v;
    @(posedge clk); #1;
    cm_valid = '0;
  endtask

  task automatic trap_pulse();
    trap_i = 1'b1;
    @(posedge clk); #1;
    trap_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int n = 0;
    while ((gq.size() != 0 || xq.size() != 0) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain_left"}, 32'(xq.size()), 32'd0);
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  // Async reset: state must clear before any clock edge arrives.
  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    gen = 0;
    gq.delete();
    xq.delete();
    m_pass = 0; m_mis = 0; m_idx = 0; m_err = 0;
    #1;
    chk("async_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("async_golden_idx", 32'(golden_idx), 32'd0);
    chk("async_flags", {28'd0, done, timeout, overflow, err_valid}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b1;
    chk("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("rst_err", {err_idx, 16'd0} | err_exp | err_got, 32'd0);
    chk("rst_handshake", {30'd0, g_ready, cm_stall}, 32'd0);
    chk("rst_test_pass", 32'(test_pass), 32'd0);
  endtask

  // Golden driver: presents the head of the golden queue.
  initial begin
    bit took;
    int tick;
    tick = 0;
    forever begin
      @(negedge clk);
      took = g_ready && reset_n;
      @(posedge clk); #1;
      if (took && gq.size() > 0) void'(gq.pop_front());
      tick++;
      g_valid = 1'b0;
      if (gen && gq.size() > 0) begin
        g_valid = (gmode == 1) ? (tick % 2 == 0) : ($urandom_range(0, 3) != 0);
        {g_type, g_pc, g_instr, g_value, g_addr, g_rd} = gq[0];
      end
    end
  end

  // Monitor: checks counters against the model, then consumes a pop.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
        chk("golden_idx", 32'(golden_idx), 32'(m_idx));
        chk("err_valid", 32'(err_valid), 32'(m_err));
        if (m_err) begin
          chk("err_idx", 32'(err_idx), m_eidx);
          chk("err_pc", err_pc, m_epc);
          chk("err_exp", err_exp, m_eexp);
          chk("err_got", err_got, m_egot);
        end
        if (g_ready) begin
          checks++;
          if (xq.size() == 0) begin
            errors++;
            $display("FAIL spurious_pop got=g_ready=1 required=no record pending");
          end else begin
            r = xq.pop_front();
            if (r.ok) m_pass++;
            else begin
              m_mis++;
              if (!m_err) begin
                m_err = 1;
                m_eidx = 32'(m_idx);
                m_epc = r.pc;
                m_eexp = r.exp;
                m_egot = r.got;
              end
            end
            m_idx++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int fr;
    logic [NCH-1:0] v;
    do_reset();

    // Single-channel in-order match.
    gen = 1; gmode = 0;
    for (int k = 0; k < 8; k++) begin
      c_rec[0] = mk(0, 32'(k*4), 32'(k*4 + 1), 32'h0, k + 1);
      g_rec[0] = c_rec[0];
      commit_cycle(4'b0001, 1);
    end
    wait_drain("t1", 200);
    trap_pulse();
    wait_done("t1", 40);
    chk("t1_pass_cnt", 32'(pass_cnt), 32'd8);
    chk("t1_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("t1_test_pass", 32'(test_pass), 32'd1);

    // Two commits in one cycle.
    do_reset();
    gen = 1;
    c_rec[0] = mk(0, 32'h40, 32'h77, 32'h0, 3);
    c_rec[1] = mk(1, 32'h44, 32'hDEADBEEF, 32'h100, 0);
    g_rec[0] = c_rec[0];
    g_rec[1] = c_rec[1];
    commit_cycle(4'b0011, 1);
    wait_drain("t2", 100);
    chk("t2_golden_idx", 32'(golden_idx), 32'd2);
    chk("t2_pass_cnt", 32'(pass_cnt), 32'd2);

    // First mismatch capture at index 3, later mismatch ignored.
    do_reset();
    gen = 1;
    for (int k = 0; k < 3; k++) begin
      c_rec[0] = mk(0, 32'h80 + 32'(k*4), 32'(k), 32'h0, 2);
      g_rec[0] = c_rec[0];
      commit_cycle(4'b0001, 1);
    end
    c_rec[0] = mk(2, 32'h8C, 32'h13, 32'h200, 5);
    g_rec[0] = mk(2, 32'h8C, 32'h12, 32'h200, 5);
    commit_cycle(4'b0001, 1);
    c_rec[0] = mk(0, 32'h90, 32'h66, 32'h0, 6);
    g_rec[0] = mk(0, 32'h90, 32'h55, 32'h0, 6);
    commit_cycle(4'b0001, 1);
    wait_drain("t3", 100);
    chk("t3_mismatch_cnt", 32'(mismatch_cnt), 32'd2);
    chk("t3_err_idx", 32'(err_idx), 32'd3);
    chk("t3_err_exp", err_exp, 32'h12);
    chk("t3_err_got", err_got, 32'h13);

    // Overflow: three full-width cycles into an 8-entry FIFO.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NCH; i++) begin
        c_rec[i] = mk(0, 32'h400 + 32'(c*16 + i*4), 32'(c*4 + i), 0, i + 1);
        g_rec[i] = c_rec[i];
      end
      commit_cycle(4'hF, c < 2);
      if (c == 0) chk("ovf_stall_c1", 32'(cm_stall), 32'd0);
      if (c == 1) chk("ovf_stall_c2", 32'(cm_stall), 32'd1);
      if (c == 1) chk("ovf_flag_c2", 32'(overflow), 32'd0);
    end
    chk("ovf_flag_c3", 32'(overflow), 32'd1);
    trap_pulse();
    gen = 1;
    wait_drain("t4", 100);
    wait_done("t4", 40);
    chk("t4_pass_cnt", 32'(pass_cnt), 32'd8);
    chk("t4_test_pass", 32'(test_pass), 32'd0);

    // Drain on trap with slow golden feed.
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      c_rec[i] = mk(3, 32'h800 + 32'(i*4), 32'(i), 0, 0);
      g_rec[i] = c_rec[i];
    end
    commit_cycle(4'hF, 1);
    c_rec[0] = mk(1, 32'h810, 32'hCAFE, 32'h300, 0);
    g_rec[0] = c_rec[0];
    commit_cycle(4'b0001, 1);
    trap_pulse();
    gmode = 1;
    gen = 1;
    for (int n = 0; n < 40 && xq.size() != 0; n++) begin
      chk("t5_drain_hold", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("t5_left", 32'(xq.size()), 32'd0);
    chk("t5_done_last_pop", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("t5_done_next", 32'(done), 32'd1);
    chk("t5_pass_cnt", 32'(pass_cnt), 32'd5);
    gmode = 0;

    // Idle timeout.
    do_reset();
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (k == TO - 1) chk("to_early", {30'd0, timeout, done}, 32'd0);
    end
    chk("to_flags", {30'd0, timeout, done}, 32'd3);
    chk("to_test_pass", 32'(test_pass), 32'd0);

    // Random stream with occasional golden corruption.
    do_reset();
    gen = 1;
    issued = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      fr = DEP - (issued - m_idx);
      v = NCH'($urandom_range(0, 15));
      for (int i = NCH - 1; i >= 0; i--)
        if ($countones(v) > fr) v[i] = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        c_rec[i] = mk($urandom_range(0, 3), $urandom & 32'hFFFF_FFFC,
                      $urandom, $urandom, $urandom_range(0, 31));
        c_rec[i].instr = $urandom;
        g_rec[i] = c_rec[i];
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 5))
            0: g_rec[i].value ^= 32'h1 << $urandom_range(0, 31);
            1: g_rec[i].addr ^= 32'h1 << $urandom_range(0, 31);
            2: g_rec[i].rd ^= 5'h1;
            3: g_rec[i].pc ^= 32'h4;
            4: g_rec[i].instr ^= 32'h80;
            default: g_rec[i].typ = 3'((g_rec[i].typ + 1) % 4);
          endcase
        end
      end
      issued += $countones(v);
      commit_cycle(v, 1);
    end
    wait_drain("rnd", 500);
    trap_pulse();
    wait_done("rnd", 40);
    chk("rnd_test_pass", 32'(test_pass), (m_mis == 0) ? 32'd1 : 32'd0);
    chk("rnd_total", 32'(golden_idx), 32'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
